// File: rtl/eq_vector_driver.sv
// Self-test driver for a 32-bit equality comparator.
// Walks a fixed 4-entry vector table, holds each X/Y pair for Settle cycles,
// samples Z once per vector and keeps pass/fail counts plus the first failing index.
module eq_vector_driver #(
  parameter int unsigned Width  = 32,
  parameter int unsigned Settle = 4   // 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  output logic [Width-1:0] x,
  output logic [Width-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [2:0]       pass_cnt,
  output logic [2:0]       fail_cnt,
  output logic [1:0]       fail_idx,
  output logic             all_pass
);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StFinish} state_e;

  localparam logic [3:0] CntLoad = 4'(Settle - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [Width-1:0] x_q, x_d, y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       pass_q, pass_d, fail_q, fail_d;
  logic [1:0]       fidx_q, fidx_d;
  logic             allp_q, allp_d;

  function automatic logic [Width-1:0] vec_x(input logic [1:0] i);
    logic [31:0] v;
    case (i)
      2'd0:    v = 32'h0000_0000;
      2'd1:    v = 32'h0000_0001;
      2'd2:    v = 32'hffff_ffff;
      default: v = 32'ha5a5_a5a5;
    endcase
    return Width'(v);
  endfunction

  function automatic logic [Width-1:0] vec_y(input logic [1:0] i);
    logic [31:0] v;
    case (i)
      2'd0:    v = 32'h0000_0000;
      2'd1:    v = 32'h0000_0000;
      2'd2:    v = 32'hff7f_ffff;
      default: v = 32'ha5a5_a5a5;
    endcase
    return Width'(v);
  endfunction

  function automatic logic vec_z(input logic [1:0] i);
    return (i == 2'd0) || (i == 2'd3);
  endfunction

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
      fidx_q  <= '0;
      allp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fidx_q  <= fidx_d;
      allp_q  <= allp_d;
    end
  end

  // Next-state logic: sequences the vectors and scores Z in CHECK.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fidx_d  = fidx_q;
    allp_d  = allp_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = 2'd0;
          x_d     = vec_x(2'd0);
          y_d     = vec_y(2'd0);
          cnt_d   = CntLoad;
          pass_d  = '0;
          fail_d  = '0;
          fidx_d  = '0;
          allp_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StCheck;
      end
      StCheck: begin
        // An unknown Z takes the else branch and scores as a fail.
        if (z == vec_z(idx_q)) begin
          pass_d = pass_q + 3'd1;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_q == 3'd0) fidx_d = idx_q;
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          x_d     = vec_x(idx_q + 2'd1);
          y_d     = vec_y(idx_q + 2'd1);
          cnt_d   = CntLoad;
          state_d = StWait;
        end else begin
          // DONE and ALL_PASS are registered on entry so both show in the FINISH cycle.
          done_d  = 1'b1;
          allp_d  = (fail_d == 3'd0);
          state_d = StFinish;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign x        = x_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign fail_idx = fidx_q;
  assign all_pass = allp_q;

endmodule

// File: tb/tb_eq_vector_driver.sv
// Directed bench for eq_vector_driver with a result scoreboard.
module tb_eq_vector_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        z;
  logic [31:0] x, y;
  logic        busy, done;
  logic [2:0]  pass_cnt, fail_cnt;
  logic [1:0]  fail_idx;
  logic        all_pass;

  int errors = 0;
  int checks = 0;
  int zmode  = 0;  // 0: ideal comparator, 1: stuck at 1, 2: stuck at 0

  typedef struct {
    logic [2:0] p;
    logic [2:0] f;
    logic [1:0] idx;
    logic       ap;
  } res_t;

  res_t sb[$];

  logic [31:0] tx [4] = '{32'h0, 32'h1, 32'hffffffff, 32'ha5a5a5a5};
  logic [31:0] ty [4] = '{32'h0, 32'h0, 32'hff7fffff, 32'ha5a5a5a5};
  logic        tz [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  eq_vector_driver #(.Width(32), .Settle(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .z        (z),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .fail_idx (fail_idx),
    .all_pass (all_pass)
  );

  always #5 clk = ~clk;

  always_comb begin
    z = 1'b0;
    if (zmode == 0)      z = (x == y);
    else if (zmode == 1) z = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input int mode);
    res_t r;
    logic zi;
    r.p = 0; r.f = 0; r.idx = 0;
    for (int i = 0; i < 4; i++) begin
      zi = (mode == 0) ? (tx[i] == ty[i]) : (mode == 1);
      if (zi == tz[i]) r.p++;
      else begin
        if (r.f == 0) r.idx = 2'(i);
        r.f++;
      end
    end
    r.ap = (r.f == 0);
    return r;
  endfunction

  // Called in cycle 1 of a run; returns in the cycle after DONE.
  task automatic wait_done(input bit chk_xy);
    bit   got = 0;
    res_t r;
    for (int n = 1; n <= 40 && !got; n++) begin
      if (chk_xy && (n % 5 == 1) && n <= 16) begin
        chk($sformatf("x_v%0d", (n - 1) / 5), x, tx[(n - 1) / 5]);
        chk($sformatf("y_v%0d", (n - 1) / 5), y, ty[(n - 1) / 5]);
      end
      if (done) begin
        got = 1;
        chk("done_cycle", n, 21);
        chk("busy_in_done", busy, 1);
        r = sb.pop_front();
        chk("pass_cnt", pass_cnt, r.p);
        chk("fail_cnt", fail_cnt, r.f);
        if (r.f != 0) chk("fail_idx", fail_idx, r.idx);
        chk("all_pass", all_pass, r.ap);
        step();
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("x_after", x, 0);
        chk("all_pass_hold", all_pass, r.ap);
      end else begin
        step();
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL done_timeout observed=no_done expected=done_by_cycle_21");
    end
  endtask

  task automatic run(input int mode);
    zmode = mode;
    start = 1'b1;
    step();
    start = 1'b0;
    sb.push_back(model(mode));
    wait_done(1'b1);
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b1;
    step();
    step();
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_fidx", fail_idx, 0);
    chk("rst_allp", all_pass, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    run(0);
    run(1);
    run(2);

    // START held high: back-to-back runs with one IDLE cycle between them.
    zmode = 2;
    start = 1'b1;
    step();
    sb.push_back(model(2));
    wait_done(1'b1);
    zmode = 0;
    step();
    chk("rerun_busy", busy, 1);
    chk("rerun_pass_clr", pass_cnt, 0);
    chk("rerun_fail_clr", fail_cnt, 0);
    chk("rerun_allp_clr", all_pass, 0);
    start = 1'b0;
    sb.push_back(model(0));
    wait_done(1'b0);

    // Reset during the v2 WAIT aborts the run.
    zmode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n < 12; n++) step();
    chk("mid_pass", pass_cnt, 2);
    chk("mid_x", x, tx[2]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_x", x, 0);
    chk("abort_y", y, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pass", pass_cnt, 0);
    chk("abort_fail", fail_cnt, 0);
    seen_done = 0;
    for (int n = 0; n < 25; n++) begin
      if (done || busy) seen_done = 1;
      step();
    end
    chk("abort_quiet", seen_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
